// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit and its buffer FIFO.
package rv_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop frees the slot a same-cycle push needs when the buffer is full.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/gnt/rvalid handling, redirect flush with discard accounting.
// Optional build macro FETCH_MISALIGN_CHK_EN adds the sticky fetch_misalign flag.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int            CW      = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_live_cnt;
  logic [CW-1:0] r_discard_cnt;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_pop;
  logic          w_push;
  logic          w_grant;
  logic          w_rsp_live;
  logic          w_hold;
  logic [CW:0]   w_credit_used;
  logic [CW:0]   w_in_flight;
  logic [31:0]   w_redirect_pc;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pop         = !w_empty && instr_ready;
  // Counting the same-cycle pop as freed credit is what sustains one fetch per cycle.
  assign w_credit_used = {1'b0, w_count} - {{CW{1'b0}}, w_pop} + {1'b0, r_live_cnt};
  assign w_in_flight   = {1'b0, r_live_cnt} + {1'b0, r_discard_cnt};

  assign imem_req   = !rst && !redirect_valid && !w_hold &&
                      (w_credit_used < DEPTH_C) && (w_in_flight < DEPTH_C);
  assign imem_addr  = r_pc;
  assign w_grant    = imem_req && imem_gnt;
  assign w_rsp_live = imem_rvalid && (r_discard_cnt == '0);
  assign w_push     = w_rsp_live && !redirect_valid;

  assign w_push_data = '{pc: r_fetch_pc, instr: imem_rdata};
  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;

  // On redirect every outstanding response, less one arriving now, belongs to the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_live_cnt    <= '0;
      r_discard_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc          <= w_redirect_pc;
      r_fetch_pc    <= w_redirect_pc;
      r_live_cnt    <= '0;
      r_discard_cnt <= r_discard_cnt + r_live_cnt - CW'(imem_rvalid);
    end else begin
      if (w_grant) r_pc <= r_pc + PC_STEP;
      if (w_push)  r_fetch_pc <= r_fetch_pc + PC_STEP;
      r_live_cnt <= r_live_cnt + CW'(w_grant) - CW'(w_rsp_live);
      if (imem_rvalid && !w_rsp_live) r_discard_cnt <= r_discard_cnt - CW'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = r_misalign;
  assign w_hold         = r_misalign;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!imem_rvalid || (w_in_flight != '0));
      assert (!(w_push && w_full && !w_pop));
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .push_data (w_push_data),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency memory model.
// Build with FETCH_MISALIGN_CHK_EN to also exercise the misaligned-redirect flag.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetchMisalign;
`endif

  int errors = 0;
  int checks = 0;
  int memLat = 1;

  typedef struct {
    logic [31:0] addr;
    int          rem;
  } memTxn_t;

  memTxn_t memQ[$];

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imemReq),
    .imem_addr      (imemAddr),
    .imem_gnt       (gnt),
    .imem_rvalid    (rvalid),
    .imem_rdata     (rdata),
    .instr_valid    (instrValid),
    .instr          (instr),
    .instr_pc       (instrPc),
    .instr_ready    (instrReady),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetchMisalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns addr^XOR_KEY memLat cycles after the grant edge, strictly in order.
  always @(posedge clk) begin
    if (rst) begin
      memQ.delete();
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      foreach (memQ[i]) memQ[i].rem = memQ[i].rem - 1;
      if (imemReq && gnt) memQ.push_back('{imemAddr, memLat - 1});
      if (memQ.size() > 0 && memQ[0].rem <= 0) begin
        rvalid <= 1'b1;
        rdata  <= memQ[0].addr ^ XOR_KEY;
        void'(memQ.pop_front());
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, outputs sampled.
  task automatic applyReset(input int lat, input logic ready, input logic g);
    @(negedge clk);
    rst           = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    instrReady    = ready;
    gnt           = g;
    memLat        = lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    instrReady = 1'b0;
    gnt = 1'b1;
    memLat = 1;
    repeat (2) tick();
    checks++;
    if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", imemReq); end
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", instrValid); end
    rst = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=00000000", imemReq, imemAddr);
    end
    repeat (3) tick();
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_prefill valid=%b pc=%h exp valid=1 pc=00000000", instrValid, instrPc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req got=%b exp=0", imemReq); end
    tick();
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got=%b exp=0", instrValid); end
    rst = 1'b0;
    #1;
    checks++;
    if (imemAddr !== 32'h0 || imemReq !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_addr req=%b addr=%h exp req=1 addr=00000000", imemReq, imemAddr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    applyReset(1, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'(4 * c)) begin
        errors++; $display("[TB] FAIL stream_addr c=%0d req=%b addr=%h exp req=1 addr=%h", c, imemReq, imemAddr, 32'(4 * c));
      end
      checks++;
      if (instrValid !== (c >= 2)) begin
        errors++; $display("[TB] FAIL stream_valid c=%0d got=%b exp=%b", c, instrValid, (c >= 2));
      end
      if (c >= 2) begin
        expPc = 32'(4 * (c - 2));
        checks++;
        if (instrPc !== expPc || instr !== (expPc ^ XOR_KEY)) begin
          errors++; $display("[TB] FAIL stream_data c=%0d pc=%h instr=%h exp pc=%h instr=%h", c, instrPc, instr, expPc, expPc ^ XOR_KEY);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    applyReset(1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        checks++;
        if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_drop c=3 got=%b exp=0", imemReq); end
      end
      if (c < 9) tick();
    end
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0 || imemReq !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_hold valid=%b pc=%h req=%b exp valid=1 pc=00000000 req=0", instrValid, instrPc, imemReq);
    end
    tick();
    instrReady = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instrValid !== 1'b1 || instrPc !== 32'(4 * k) || instr !== (32'(4 * k) ^ XOR_KEY)) begin
        errors++; $display("[TB] FAIL bp_drain k=%0d valid=%b pc=%h exp valid=1 pc=%h", k, instrValid, instrPc, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_latency();
    bit found = 0;
    bit seenReq = 0;
    applyReset(3, 1'b1, 1'b1);
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("[TB] FAIL lat_req0 req=%b addr=%h exp req=1 addr=00000000", imemReq, imemAddr); end
    tick();
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin errors++; $display("[TB] FAIL lat_req1 req=%b addr=%h exp req=1 addr=00000004", imemReq, imemAddr); end
    tick();
    redirectValid = 1'b1;
    redirectPc    = 32'h100;
    #1;
    checks++;
    if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL lat_redirect_req got=%b exp=0", imemReq); end
    tick();
    redirectValid = 1'b0;
    #1;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imemReq === 1'b1 && !seenReq) begin
        seenReq = 1;
        checks++;
        if (imemAddr !== 32'h100) begin errors++; $display("[TB] FAIL lat_new_addr got=%h exp=00000100", imemAddr); end
      end
      if (instrValid === 1'b1) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL lat_timeout valid=%b exp=1 within 20 cycles", instrValid);
    end else if (instrPc !== 32'h100 || instr !== (32'h100 ^ XOR_KEY)) begin
      errors++; $display("[TB] FAIL lat_first pc=%h instr=%h exp pc=00000100 instr=%h", instrPc, instr, 32'h100 ^ XOR_KEY);
    end
  endtask

  task automatic test_redirect_coincident();
    bit found = 0;
    applyReset(1, 1'b0, 1'b1);
    repeat (2) tick();
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
      errors++; $display("[TB] FAIL coin_setup valid=%b pc=%h exp valid=1 pc=00000000", instrValid, instrPc);
    end
    instrReady    = 1'b1;
    redirectValid = 1'b1;
    redirectPc    = 32'h300;
    #1;
    tick();
    redirectValid = 1'b0;
    #1;
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL coin_flush valid=%b exp=0", instrValid); end
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h300) begin
      errors++; $display("[TB] FAIL coin_refetch req=%b addr=%h exp req=1 addr=00000300", imemReq, imemAddr);
    end
    for (int k = 0; k < 20 && !found; k++) begin
      if (instrValid === 1'b1) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL coin_timeout valid=%b exp=1 within 20 cycles", instrValid);
    end else if (instrPc !== 32'h300 || instr !== (32'h300 ^ XOR_KEY)) begin
      errors++; $display("[TB] FAIL coin_first pc=%h instr=%h exp pc=00000300 instr=%h", instrPc, instr, 32'h300 ^ XOR_KEY);
    end
  endtask

  task automatic test_gnt_stall_wrap();
    applyReset(1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
        errors++; $display("[TB] FAIL stall_addr c=%0d req=%b addr=%h exp req=1 addr=00000000", c, imemReq, imemAddr);
      end
      tick();
    end
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFC;
    #1;
    tick();
    redirectValid = 1'b0;
    gnt           = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_top req=%b addr=%h exp req=1 addr=fffffffc", imemReq, imemAddr);
    end
    tick();
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_addr req=%b addr=%h exp req=1 addr=00000000", imemReq, imemAddr);
    end
    tick();
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'hFFFF_FFFC || instr !== 32'h5A5A_FFFC) begin
      errors++; $display("[TB] FAIL wrap_data0 valid=%b pc=%h instr=%h exp valid=1 pc=fffffffc instr=5a5afffc", instrValid, instrPc, instr);
    end
    tick();
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0 || instr !== 32'hA5A5_0000) begin
      errors++; $display("[TB] FAIL wrap_data1 valid=%b pc=%h instr=%h exp valid=1 pc=00000000 instr=a5a50000", instrValid, instrPc, instr);
    end
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    bit found = 0;
    applyReset(1, 1'b1, 1'b1);
    checks++;
    if (fetchMisalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_reset got=%b exp=0", fetchMisalign); end
    repeat (2) tick();
    redirectValid = 1'b1;
    redirectPc    = 32'h102;
    #1;
    tick();
    redirectValid = 1'b0;
    #1;
    checks++;
    if (fetchMisalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_set got=%b exp=1", fetchMisalign); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
        errors++; $display("[TB] FAIL mis_hold c=%0d req=%b valid=%b exp req=0 valid=0", c, imemReq, instrValid);
      end
      tick();
    end
    redirectValid = 1'b1;
    redirectPc    = 32'h200;
    #1;
    tick();
    redirectValid = 1'b0;
    #1;
    checks++;
    if (fetchMisalign !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      errors++; $display("[TB] FAIL mis_clear flag=%b req=%b addr=%h exp flag=0 req=1 addr=00000200", fetchMisalign, imemReq, imemAddr);
    end
    for (int k = 0; k < 20 && !found; k++) begin
      if (instrValid === 1'b1) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL mis_timeout valid=%b exp=1 within 20 cycles", instrValid);
    end else if (instrPc !== 32'h200) begin
      errors++; $display("[TB] FAIL mis_resume pc=%h exp=00000200", instrPc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_coincident();
    test_gnt_stall_wrap();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
